// File: rtl/module_display_7seg.sv
// module_display_7seg: 4-digit multiplexed common-anode 7-seg scan driver.
// Build option: LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module module_display_7seg #(
  parameter int REFRESH_DIV = 27000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] first_num,
  input  logic [7:0] second_num,
  input  logic       listo_1,
  input  logic       listo_2,
  output logic [3:0] anodo,
  output logic [6:0] seg,
  output logic       frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef enum logic [1:0] {
    SHOW_A,
    SHOW_B,
    SHOW_AB
  } mode_t;

  logic [CW-1:0] div_cnt;
  logic [1:0]    idx;
  logic          tick;
  logic          frame_end;
  logic [7:0]    snap_a;
  logic [7:0]    snap_b;
  mode_t         mode;
  mode_t         mode_nxt;
  mode_t         mode_q;
  logic [3:0]    nib;
  logic          blank;
  logic          tens;

  assign tick      = (div_cnt == LAST);
  assign frame_end = tick && (idx == 2'd3);

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Refresh divider and slot index.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick)
        idx <= idx + 2'd1;
    end
  end

  // Frame boundary: pulse and snapshot operands plus mode together.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      snap_a     <= 8'h00;
      snap_b     <= 8'h00;
      mode_q     <= SHOW_A;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        snap_a <= first_num;
        snap_b <= second_num;
        mode_q <= mode;
      end
    end
  end

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst)
      mode <= SHOW_A;
    else
      mode <= mode_nxt;
  end

  // Mode next-state: follows the entry-done flags.
  always_comb begin
    mode_nxt = mode;
    case (mode)
      SHOW_A: begin
        if (listo_1 && listo_2)
          mode_nxt = SHOW_AB;
        else if (listo_1)
          mode_nxt = SHOW_B;
      end
      SHOW_B: begin
        if (listo_2)
          mode_nxt = SHOW_AB;
      end
      SHOW_AB: begin
        if (!listo_1 && !listo_2)
          mode_nxt = SHOW_A;
      end
      default: mode_nxt = SHOW_A;
    endcase
  end

  // Pick the nibble for the current slot, or blank it.
  always_comb begin
    nib   = 4'h0;
    blank = 1'b1;
    tens  = idx[0];
    case (mode_q)
      SHOW_A: begin
        if (!idx[1]) begin
          blank = 1'b0;
          nib   = idx[0] ? snap_a[7:4] : snap_a[3:0];
        end
      end
      SHOW_B: begin
        if (!idx[1]) begin
          blank = 1'b0;
          nib   = idx[0] ? snap_b[7:4] : snap_b[3:0];
        end
      end
      SHOW_AB: begin
        blank = 1'b0;
        unique case (idx)
          2'd3: nib = snap_a[7:4];
          2'd2: nib = snap_a[3:0];
          2'd1: nib = snap_b[7:4];
          2'd0: nib = snap_b[3:0];
        endcase
      end
      default: blank = 1'b1;
    endcase
    if (LZB && tens && nib == 4'h0)
      blank = 1'b1;
  end

  // Output register: anode and segments switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      anodo <= 4'hF;
      seg   <= 7'h7F;
    end else if (tick) begin
      if (blank) begin
        anodo <= 4'hF;
        seg   <= 7'h7F;
      end else begin
        anodo <= ~(4'b0001 << idx);
        seg   <= dec7(nib);
      end
    end
  end

endmodule

// File: tb/tb_module_display_7seg.sv
// tb_module_display_7seg: random + directed bench with a frame-level model.
// Build option: LEADING_ZERO_BLANK_EN must match the RTL build.
module tb_module_display_7seg;

  localparam int R = 4;
  localparam int FR = 4 * R;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] first_num;
  logic [7:0] second_num;
  logic       listo_1;
  logic       listo_2;
  logic [3:0] anodo;
  logic [6:0] seg;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  module_display_7seg #(.REFRESH_DIV(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .first_num  (first_num),
    .second_num (second_num),
    .listo_1    (listo_1),
    .listo_2    (listo_2),
    .anodo      (anodo),
    .seg        (seg),
    .frame_done (frame_done)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                               7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000, 7'b0000000,
                               7'b0010000};
  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // mode: 0 = A only, 1 = B only, 2 = A left and B right
  function automatic logic [10:0] render(input int slot, input logic [7:0] a,
                                         input logic [7:0] b, input int md);
    logic [3:0] n;
    bit show;
    bit is_tens;
    show = 0;
    n = 4'h0;
    is_tens = (slot % 2) == 1;
    if (md == 0 && slot < 2) begin
      show = 1;
      n = is_tens ? a[7:4] : a[3:0];
    end else if (md == 1 && slot < 2) begin
      show = 1;
      n = is_tens ? b[7:4] : b[3:0];
    end else if (md == 2) begin
      show = 1;
      if (slot >= 2) n = is_tens ? a[7:4] : a[3:0];
      else           n = is_tens ? b[7:4] : b[3:0];
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (is_tens && n == 4'h0) show = 0;
`endif
    if (!show) return {4'hF, 7'h7F};
    return {an_tab[slot], (n > 9) ? 7'b0111111 : seg_tab[n]};
  endfunction

  function automatic int next_mode(input int md, input logic l1,
                                   input logic l2);
    if (md == 0) return (l1 && l2) ? 2 : (l1 ? 1 : 0);
    if (md == 1) return l2 ? 2 : 1;
    return (!l1 && !l2) ? 0 : 2;
  endfunction

  // Model state, expressed in edges since reset release.
  int         t = 0;
  bit         armed = 0;
  logic [7:0] m_sa;
  logic [7:0] m_sb;
  int         m_mode;
  int         m_modeq;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_fd;

  always @(posedge clk) begin
    logic [10:0] r;
    if (rst) begin
      armed = 1;
      t = 0;
      m_sa = 8'h00;
      m_sb = 8'h00;
      m_mode = 0;
      m_modeq = 0;
      m_an = 4'hF;
      m_seg = 7'h7F;
      m_fd = 1'b0;
    end else if (armed) begin
      t = t + 1;
      m_fd = (t % FR) == 0;
      if (t % R == 0) begin
        r = render((t / R - 1) % 4, m_sa, m_sb, m_modeq);
        m_an = r[10:7];
        m_seg = r[6:0];
      end
      if (m_fd) begin
        m_sa = first_num;
        m_sb = second_num;
        m_modeq = m_mode;
      end
      m_mode = next_mode(m_mode, listo_1, listo_2);
    end
    if (armed) begin
      #1;
      chk("model_anodo", 32'(anodo), 32'(m_an));
      chk("model_seg", 32'(seg), 32'(m_seg));
      chk("model_frame_done", 32'(frame_done), 32'(m_fd));
    end
  end

  int tcur;

  task automatic goto(input int k);
    while (tcur < k) begin
      @(negedge clk);
      tcur++;
    end
  endtask

  task automatic lit(input string nm, input logic [3:0] ea,
                     input logic [6:0] es);
    chk({nm, "_anodo"}, 32'(anodo), 32'(ea));
    chk({nm, "_seg"}, 32'(seg), 32'(es));
  endtask

  initial begin
    rst = 1'b1;
    first_num = 8'h00;
    second_num = 8'h00;
    listo_1 = 1'b0;
    listo_2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tcur = 0;

    goto(3);
    lit("pre_tick", 4'hF, 7'h7F);
    chk("pre_tick_fd", 32'(frame_done), 32'd0);
    goto(4);
    lit("reset_slot0", 4'b1110, 7'b1000000);
    goto(12);
    lit("reset_slot2", 4'hF, 7'h7F);
    goto(15);
    chk("fd_15", 32'(frame_done), 32'd0);
    goto(16);
    chk("fd_16", 32'(frame_done), 32'd1);
    lit("reset_slot3", 4'hF, 7'h7F);
    goto(17);
    chk("fd_17", 32'(frame_done), 32'd0);
    first_num = 8'h47;

    goto(36);
    lit("a47_slot0", 4'b1110, 7'b1111000);
    goto(40);
    lit("a47_slot1", 4'b1101, 7'b0011001);
    goto(41);
    listo_1 = 1'b1;
    second_num = 8'h09;

    goto(52);
    lit("b09_slot0", 4'b1110, 7'b0010000);
    goto(56);
`ifdef LEADING_ZERO_BLANK_EN
    lit("b09_slot1", 4'hF, 7'h7F);
`else
    lit("b09_slot1", 4'b1101, 7'b1000000);
`endif
    goto(57);
    listo_2 = 1'b1;
    second_num = 8'h12;

    goto(68);
    lit("ab_slot0", 4'b1110, 7'b0100100);
    goto(72);
    lit("ab_slot1", 4'b1101, 7'b1111001);
    goto(76);
    lit("ab_slot2", 4'b1011, 7'b1111000);
    goto(80);
    lit("ab_slot3", 4'b0111, 7'b0011001);
    goto(81);
    listo_1 = 1'b0;
    listo_2 = 1'b0;
    first_num = 8'h3C;

    goto(100);
    lit("dash_slot0", 4'b1110, 7'b0111111);
    goto(101);
    first_num = 8'h25;
    goto(104);
    lit("hold_slot1", 4'b1101, 7'b0110000);
    goto(116);
    lit("new_slot0", 4'b1110, 7'b0010010);

    goto(125);
    rst = 1'b1;
    goto(126);
    lit("mid_rst", 4'hF, 7'h7F);
    chk("mid_rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    tcur = 0;
    goto(15);
    chk("rst_fd_15", 32'(frame_done), 32'd0);
    goto(16);
    chk("rst_fd_16", 32'(frame_done), 32'd1);
    goto(31);
    chk("rst_fd_31", 32'(frame_done), 32'd0);
    goto(32);
    chk("rst_fd_32", 32'(frame_done), 32'd1);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) first_num = 8'($urandom);
      if ($urandom_range(0, 5) == 0) second_num = 8'($urandom);
      if ($urandom_range(0, 9) == 0) listo_1 = ~listo_1;
      if ($urandom_range(0, 9) == 0) listo_2 = ~listo_2;
      if ($urandom_range(0, 39) == 0) begin
        listo_1 = 1'b0;
        listo_2 = 1'b0;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
